// File: rtl/fpu_pkg.sv
// Shared binary64 field widths, FPU opcode encodings and result-flag bit positions.
package fpu_pkg;

  localparam int DBL_W   = 64;
  localparam int EXP_W   = 11;
  localparam int MAN_W   = 52;
  localparam int FLAGS_W = 4;
  localparam int OP_W    = 2;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_MUL = 2'b10;
  localparam logic [OP_W-1:0] OP_DIV = 2'b11;

  localparam int FLG_NAN  = 3;
  localparam int FLG_INF  = 2;
  localparam int FLG_ZERO = 1;
  localparam int FLG_SUB  = 0;

  function automatic logic [EXP_W-1:0] dbl_exp(input logic [DBL_W-1:0] v);
    return v[DBL_W-2 -: EXP_W];
  endfunction

  function automatic logic [MAN_W-1:0] dbl_man(input logic [DBL_W-1:0] v);
    return v[MAN_W-1:0];
  endfunction

endpackage

// File: rtl/fpu_cmd_queue_if.sv
// Command, FPU-side and result handshake bundle for fpu_cmd_queue; out_flags exists only with FPU_FLAGS_EN.
interface fpu_cmd_queue_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) ();
  import fpu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               in_valid;
  logic               in_ready;
  logic [DBL_W-1:0]   in_a;
  logic [DBL_W-1:0]   in_b;
  logic [OP_W-1:0]    in_op;
  logic [TAG_W-1:0]   in_tag;

  logic [DBL_W-1:0]   fpu_a;
  logic [DBL_W-1:0]   fpu_b;
  logic [OP_W-1:0]    fpu_op;
  logic [DBL_W-1:0]   fpu_result;

  logic               out_valid;
  logic               out_ready;
  logic [DBL_W-1:0]   out_result;
  logic [TAG_W-1:0]   out_tag;
`ifdef FPU_FLAGS_EN
  logic [FLAGS_W-1:0] out_flags;
`endif

  logic [CNT_W-1:0]   count;

`ifdef FPU_FLAGS_EN
  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, fpu_result, out_ready,
    input  in_ready, fpu_a, fpu_b, fpu_op, out_valid, out_result, out_tag, out_flags, count
  );
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, fpu_result, out_ready,
    output in_ready, fpu_a, fpu_b, fpu_op, out_valid, out_result, out_tag, out_flags, count
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, fpu_result, out_ready,
    input  in_ready, fpu_a, fpu_b, fpu_op, out_valid, out_result, out_tag, count
  );
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, fpu_result, out_ready,
    output in_ready, fpu_a, fpu_b, fpu_op, out_valid, out_result, out_tag, count
  );
`endif

endinterface

// File: rtl/fpu_result_classify.sv
// Combinational binary64 classifier producing {nan, inf, zero, subnormal}; zero latency, no handshake.
module fpu_result_classify
  import fpu_pkg::*;
(
  input  logic [DBL_W-1:0]   i_val,
  output logic [FLAGS_W-1:0] o_flags
);

  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_man;
  logic             w_exp_ones;
  logic             w_exp_zero;
  logic             w_man_zero;

  assign w_exp      = dbl_exp(i_val);
  assign w_man      = dbl_man(i_val);
  assign w_exp_ones = &w_exp;
  assign w_exp_zero = ~|w_exp;
  assign w_man_zero = ~|w_man;

  always_comb begin
    o_flags           = '0;
    o_flags[FLG_NAN]  = w_exp_ones & ~w_man_zero;
    o_flags[FLG_INF]  = w_exp_ones &  w_man_zero;
    o_flags[FLG_ZERO] = w_exp_zero &  w_man_zero;
    o_flags[FLG_SUB]  = w_exp_zero & ~w_man_zero;
  end

endmodule

// File: rtl/fpu_cmd_queue.sv
// DEPTH-entry command FIFO feeding a combinational FPU, result captured one edge after reaching the head.
// in_ready comes from registered count only; FPU_FLAGS_EN adds registered out_flags classification.
module fpu_cmd_queue
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input logic              clk,
  input logic              rst,
  fpu_cmd_queue_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [DBL_W-1:0] a;
    logic [DBL_W-1:0] b;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  cmd_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  logic [DBL_W-1:0] r_out_result;
  logic [TAG_W-1:0] r_out_tag;

  cmd_t             w_in_cmd;
  cmd_t             w_head;
  logic             w_empty;
  logic             w_in_ready;
  logic             w_push;
  logic             w_issue;
  logic             w_drain;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_empty    = (r_count == '0);
  assign w_in_ready = (r_count != FULL_CNT);
  assign w_push     = bus.in_valid & w_in_ready;
  assign w_issue    = ~w_empty & (~r_out_valid | bus.out_ready);
  assign w_drain    = r_out_valid & bus.out_ready & w_empty;

  assign w_in_cmd = '{a: bus.in_a, b: bus.in_b, op: bus.in_op, tag: bus.in_tag};
  assign w_head   = r_mem[r_rd_ptr];

  // Storage is deliberately left out of reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_cmd;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_issue})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
    end else if (w_issue) begin
      r_out_valid  <= 1'b1;
      r_out_result <= bus.fpu_result;
      r_out_tag    <= w_head.tag;
    end else if (w_drain) begin
      r_out_valid  <= 1'b0;
    end
  end

  // Head is zeroed while empty so the FPU never sees stale storage.
  always_comb begin
    bus.fpu_a  = '0;
    bus.fpu_b  = '0;
    bus.fpu_op = OP_ADD;
    if (!w_empty) begin
      bus.fpu_a  = w_head.a;
      bus.fpu_b  = w_head.b;
      bus.fpu_op = w_head.op;
    end
  end

`ifdef FPU_FLAGS_EN
  logic [FLAGS_W-1:0] w_flags;
  logic [FLAGS_W-1:0] r_out_flags;

  fpu_result_classify u_classify (
    .i_val   (bus.fpu_result),
    .o_flags (w_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_flags <= '0;
    end else if (w_issue) begin
      r_out_flags <= w_flags;
    end
  end

  assign bus.out_flags = r_out_flags;
`endif

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_tag    = r_out_tag;
  assign bus.count      = r_count;

endmodule
